board_frame_tx: RTL and testbench

- Transmit side of the board link between the two players' boards.
- On a start pulse, scans all 100 cells of the local (host) board through the board read port and packs the 2-bit ship codes four per byte.
- Streams a framed byte sequence to the UART transmitter over a valid/ready handshake.
- The opponent's receiver uses the frame to fill its guest board.

---
 rtl/board_frame_tx.sv | 83 ++++++++
 tb/tb_board_frame_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/board_frame_tx.sv
// board_frame_tx: scans the host board, packs 2-bit cell codes four per byte and streams a framed byte sequence.
// Define BOARD_TX_CHECKSUM_EN to append an XOR checksum byte after the payload.
module board_frame_tx #(
  parameter int          CELLS    = 100,
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int          READ_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [6:0] rd_xy,
  input  logic [1:0] rd_code,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);
  localparam int WW = $clog2(READ_LAT) + 1;
`ifdef BOARD_TX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, READ, WAIT, SEND, CSUM, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, READ, WAIT, SEND, FIN} state_t;
`endif
  state_t state, nxt;
  logic [6:0] idx;
  logic [7:0] pack, csum_byte;
  logic [WW-1:0] wcnt;
  logic last_wait, last_cell, is_csum;
  assign last_wait = wcnt == WW'(READ_LAT - 1);
  assign last_cell = idx == 7'(CELLS - 1);
  assign rd_xy = idx;
  assign tx_valid = state == HDR || state == SEND || is_csum;
  assign tx_data = state == HDR ? HEADER : state == SEND ? pack : csum_byte;
  assign busy = state != IDLE && state != FIN;
  assign done = state == FIN;
`ifdef BOARD_TX_CHECKSUM_EN
  logic [7:0] csum;
  assign is_csum = state == CSUM;
  assign csum_byte = is_csum ? csum : 8'h00;
  always_ff @(posedge clk)
    if (!rst) csum <= '0;
    else if (state == IDLE && start) csum <= '0;
    else if (tx_valid && tx_ready && !is_csum) csum <= csum ^ tx_data;
`else
  assign is_csum = 1'b0;
  assign csum_byte = 8'h00;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      pack <= '0;
      wcnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) idx <= '0;
      if (state == READ) wcnt <= '0;
      if (state == WAIT && !last_wait) wcnt <= wcnt + WW'(1);
      if (state == WAIT && last_wait) pack[{idx[1:0], 1'b0} +: 2] <= rd_code;
      if ((state == WAIT && last_wait && idx[1:0] != 2'd3) || (state == SEND && tx_ready && !last_cell))
        idx <= idx + 7'd1;
      if (state == SEND && tx_ready) pack <= '0;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start ? HDR : IDLE;
      HDR:  nxt = tx_ready ? READ : HDR;
      READ: nxt = WAIT;
      WAIT: nxt = !last_wait ? WAIT : idx[1:0] == 2'd3 ? SEND : READ;
`ifdef BOARD_TX_CHECKSUM_EN
      SEND: nxt = !tx_ready ? SEND : last_cell ? CSUM : READ;
      CSUM: nxt = tx_ready ? FIN : CSUM;
`else
      SEND: nxt = !tx_ready ? SEND : last_cell ? FIN : READ;
`endif
      FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_board_frame_tx.sv
// tb_board_frame_tx: random boards and ready patterns against a byte-level frame model.
module tb_board_frame_tx;
  logic clk = 0, rst = 0, start = 0, tx_ready = 1;
  logic [1:0] rd_code = 0;
  logic [6:0] rd_xy;
  logic [7:0] tx_data;
  logic tx_valid, busy, done;
  board_frame_tx dut (.clk(clk), .rst(rst), .start(start), .rd_xy(rd_xy), .rd_code(rd_code),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [1:0] board [100];
  logic [7:0] exp_q [$], rx [$];
  int xy_q [$];
  int last_xy = -1, cyc = 0, last_hs = 0, done_cyc = 0, done_cnt = 0, stall_n = 0, hold = 0, xy_s = 0;
  bit stall_req = 0, rand_ready = 0, prev_stall = 0;
  logic [7:0] prev_data = 0;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void build_exp();
    logic [7:0] b, cs;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'hA5;
    for (int i = 0; i < 25; i++) begin
      b = 0;
      for (int k = 0; k < 4; k++) b = b | (8'(board[4*i+k]) << (2*k));
      exp_q.push_back(b);
      cs = cs ^ b;
    end
`ifdef BOARD_TX_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction
  initial forever begin
    @(negedge clk);
    xy_s = int'(rd_xy);
    @(posedge clk);
    #1 rd_code = xy_s < 100 ? board[xy_s] : 2'b00;
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_req && hold < 5 && rx.size() == 2 && tx_valid) begin
      tx_ready = 0;
      hold++;
    end else tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (prev_stall) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        rx.push_back(tx_data);
        last_hs = cyc;
      end
      if (tx_valid && !tx_ready && rx.size() == 2) stall_n++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy && int'(rd_xy) != last_xy) begin
        xy_q.push_back(int'(rd_xy));
        last_xy = int'(rd_xy);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
    end else prev_stall = 0;
  end
  task automatic kick();
    build_exp();
    rx.delete();
    xy_q.delete();
    last_xy = -1;
    done_cnt = 0;
    stall_n = 0;
    hold = 0;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic run_frame(input bit restart, input bit stall, input bit xy_chk, input bit at_done);
    bit injected = 0;
    stall_req = stall;
    kick();
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      @(posedge clk);
      #1 start = 0;
      if (restart && !injected && rx.size() >= 10) begin
        start = 1;
        injected = 1;
      end
      if (at_done && done) start = 1;
    end
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    #1;
    if (done_cnt == 0) chk("timeout", 0, 1);
    chk("done_cnt", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("valid_after", tx_valid, 0);
    chk("len", rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++) chk($sformatf("byte%0d", i), rx[i], exp_q[i]);
    chk("done_timing", done_cyc, last_hs + 1);
    if (stall) chk("stall_cycles", stall_n, 5);
    if (xy_chk) begin
      chk("xy_count", xy_q.size(), 100);
      for (int i = 0; i < xy_q.size(); i++) chk($sformatf("xy%0d", i), xy_q[i], i);
    end
    stall_req = 0;
  endtask
  task automatic rand_board();
    for (int i = 0; i < 100; i++) board[i] = 2'($urandom_range(0, 3));
  endtask
  initial begin
    for (int i = 0; i < 100; i++) board[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_xy", rd_xy, 0);
    chk("rst_data", tx_data, 0);
    rst = 1;
    board[0] = 2'b10;
    board[99] = 2'b10;
    run_frame(0, 0, 1, 0);
    chk("first_payload", rx.size() > 1 ? rx[1] : 0, 8'h02);
    chk("last_payload", rx.size() > 25 ? rx[25] : 0, 8'h80);
`ifdef BOARD_TX_CHECKSUM_EN
    chk("csum_27", rx.size() > 26 ? rx[26] : 0, 8'h27);
`endif
    for (int i = 0; i < 100; i++) board[i] = 0;
    board[0] = 2'b01;
    board[1] = 2'b10;
    board[2] = 2'b11;
    run_frame(0, 1, 1, 0);
    chk("byte1_39", rx.size() > 1 ? rx[1] : 0, 8'h39);
    rand_board();
    rand_ready = 1;
    run_frame(1, 0, 0, 1);
    run_frame(0, 0, 1, 0);
    rand_board();
    kick();
    for (int c = 0; c < 3000 && rx.size() < 12; c++) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1 rst = 1;
    chk("abort_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_xy", rd_xy, 0);
    repeat (30) @(posedge clk);
    #1 chk("abort_no_done", done_cnt, 0);
    run_frame(0, 0, 1, 0);
    for (int f = 0; f < 3; f++) begin
      rand_board();
      run_frame(0, f == 1, 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
